fifo_rd_drain: RTL

Read-side consumer engine for the dual-clock FIFO top, living entirely in the read clock domain. It pops words from the FIFO read port with `enable_rd` while respecting `f_empty`, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the words downstream on a valid/ready stream. It also keeps a delivered-word count and a running XOR checksum.

---
 rtl/fifo_rd_drain_if.sv | 33 +++
 rtl/fifo_rd_drain.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain_if.sv
// FIFO read-port and downstream stream signals of the read-side drain engine.
// The master modport is the drain engine; the slave modport is the FIFO plus sink.
interface fifo_rd_drain_if #(
    parameter int DATA_WIDTH = 8
);
    // FIFO read port (rd_clk domain)
    logic                  f_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  enable_rd;

    // downstream valid/ready stream
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  f_empty,
        input  fifo_data,
        input  m_ready,
        output enable_rd,
        output m_data,
        output m_valid
    );

    modport slave (
        output f_empty,
        output fifo_data,
        output m_ready,
        input  enable_rd,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: pops the FIFO, hides its one-cycle read latency in a
// 2-entry buffer, and streams words downstream with a count and XOR checksum.
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic                  drain_en,
    fifo_rd_drain_if.master       bus,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_inflight;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic [CNT_WIDTH-1:0]  r_word_count;
    logic [DATA_WIDTH-1:0] r_checksum;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_credit;
    logic [2:0]            w_limit;
    logic                  w_enable_rd;

    // Handshake and credit: words already owned (buffered + in flight) minus the
    // one leaving this edge must be below 2, so every arrival finds a free slot.
    assign w_pop       = (r_occ != 2'd0) & bus.m_ready;
    assign w_push      = r_inflight;
    assign w_credit    = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_limit     = 3'd2 + {2'b00, w_pop};
    assign w_enable_rd = (r_state == S_RUN) & ~bus.f_empty & ~reset & (w_credit < w_limit);

    assign bus.enable_rd = w_enable_rd;
    assign bus.m_valid   = (r_occ != 2'd0);
    assign bus.m_data    = r_buf[0];
    assign word_count    = r_word_count;
    assign checksum      = r_checksum;
    assign busy          = (r_state != S_IDLE) | r_inflight | (r_occ != 2'd0);

    // State register.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: FLUSH waits for the pipe and buffer to empty unless drain resumes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (drain_en) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!drain_en) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (drain_en)
                    w_state_nxt = S_RUN;
                else if (!r_inflight && (r_occ == 2'd0))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read-latency tracker: a pop issued this edge returns data next cycle.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_enable_rd;
        end
    end

    // Output buffer, head at entry 0; push and pop on one edge keep FIFO order.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            r_occ    <= 2'd0;
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_buf[r_occ[0]] <= bus.fifo_data;
                    r_occ           <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf[0] <= r_buf[1];
                    r_occ    <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf[0] <= bus.fifo_data;
                    end else begin
                        r_buf[0] <= r_buf[1];
                        r_buf[1] <= bus.fifo_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Delivery statistics, updated on every downstream handshake.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            r_word_count <= '0;
            r_checksum   <= '0;
        end else if (w_pop) begin
            r_word_count <= r_word_count + 1'b1;
            r_checksum   <= r_checksum ^ r_buf[0];
        end
    end

endmodule
